aes_req_seq: RTL and testbench
==============================

Name: aes_req_seq

Overview:
- Request sequencer directly upstream of aes_top. Also acts as the result buffer directly downstream of it.
- Accepts one encrypt/decrypt job at a time over a valid/ready interface and drives aes_top's mode/ld/kld/key/text_in.
- For decryption, it issues the key-load and key-expansion wait that the inverse cipher requires before ld. It skips both when the decrypt key matches the last expanded key.
- Captures text_out on done, holds it in an output register, and supplies a timeout watchdog.

Parameters:
- KEXP_CYCLES, 12: cycles to wait after core_kld before core_ld is allowed in decrypt mode.
- TIMEOUT, 64: maximum cycles in RUN without core_done before the job is aborted with an error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  job request
- in_ready  out  1  sequencer can accept a job
- in_mode  in  1  0=encrypt, 1=decrypt
- in_key  in  128  AES key
- in_text  in  128  plaintext or ciphertext
- core_mode  out  1  to aes_top mode
- core_ld  out  1  to aes_top ld (single-cycle pulse)
- core_kld  out  1  to aes_top kld (single-cycle pulse)
- core_key  out  128  to aes_top key
- core_text  out  128  to aes_top text_in
- core_done  in  1  from aes_top done
- core_text_out  in  128  from aes_top text_out
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_text  out  128  result block
- out_mode  out  1  mode of the job that produced the result
- out_err  out  1  1 = job aborted by timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-job:
  - state=IDLE; key_valid=0; all counters 0.
  - core_ld=0, core_kld=0, core_mode=0, core_key=0, core_text=0.
  - out_valid=0, out_text=0, out_mode=0, out_err=0; in_ready=1 after reset deasserts; busy=0.
- Job registers:
  - in_ready=1 only in IDLE.
  - Accept = in_valid & in_ready. On accept, mode/key/text are registered into core_mode/core_key/core_text.
  - These outputs stay stable until the next accept.
- IDLE, on accept:
  - mode=0 -> LOAD.
  - mode=1 with key_valid=1 and in_key==cached_key -> LOAD.
  - Otherwise mode=1 -> KLOAD.
- KLOAD (1 cycle):
  - core_kld=1; cached_key<=core_key; key_valid<=0; counter cleared.
  - Next state KWAIT.
- KWAIT:
  - Counts KEXP_CYCLES cycles. On the last one, key_valid<=1 -> LOAD.
- LOAD (1 cycle):
  - core_ld=1; timeout counter cleared.
  - Next state RUN.
- RUN:
  - On core_done=1: out_text<=core_text_out, out_mode<=core_mode, out_err<=0 -> HOLD.
  - If the counter reaches TIMEOUT-1 without done: out_text<=0, out_err<=1, key_valid<=0 -> HOLD.
  - core_done and timeout in the same cycle: done wins.
- HOLD:
  - out_valid=1; out_text, out_mode and out_err are held stable while out_ready=0.
  - On out_ready=1: out_valid drops the next cycle and state -> IDLE.
  - No bypass: the earliest next accept is the cycle after the output handshake.
- core_done seen outside RUN is ignored and does not change any output.
- Encrypt jobs never touch key_valid or cached_key.
- core_ld and core_kld are never asserted in the same cycle. At most one core_ld per accepted job.
- Latency:
  - Encrypt: accept at edge 0, core_ld high in cycle 1. If core_done arrives in cycle D, out_valid is high from cycle D+1.
  - Decrypt with a new key: core_kld in cycle 1, core_ld in cycle 2+KEXP_CYCLES.
  - Decrypt with a cached key: same timing as encrypt.

Test Plan:
- Reset mid-KWAIT, then rst=0 -> next cycle all outputs are 0, in_ready=1, and a following decrypt re-issues core_kld (key_valid was cleared).
- Encrypt: key=000102..0f, text=00112233..ff; model core_done 11 cycles after core_ld with 69c4e0d86a7b0430d8cdb78070b4c55a -> out_valid=1, out_text matches, out_mode=0, out_err=0, core_kld never asserted.
- Decrypt, same key, text=69c4..5a -> core_kld pulse, core_ld exactly KEXP_CYCLES+1 cycles after it, out_text=00112233445566778899aabbccddeeff. A second decrypt with the same key -> no core_kld, core_ld one cycle after accept.
- Back-pressure: out_ready=0 for 20 cycles after the result -> out_valid and out_text stable, in_ready=0 throughout, new in_valid not accepted; out_ready=1 -> IDLE next cycle.
- Timeout: core_done withheld -> exactly TIMEOUT cycles after core_ld's cycle, out_valid=1, out_err=1, out_text=0. A next decrypt with the same key issues core_kld.
- Spurious core_done in IDLE and in KWAIT -> no out_valid, no state change. An interleaved encrypt between two same-key decrypts does not force a re-kld.

Source files
------------

// File: rtl/aes_req_seq_if.sv
// Job request, aes_top control and result signals of the AES request sequencer.
interface aes_req_seq_if;
  localparam int unsigned BLK_W = 128;

  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [BLK_W-1:0] in_key;
  logic [BLK_W-1:0] in_text;

  logic             core_mode;
  logic             core_ld;
  logic             core_kld;
  logic [BLK_W-1:0] core_key;
  logic [BLK_W-1:0] core_text;
  logic             core_done;
  logic [BLK_W-1:0] core_text_out;

  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_text;
  logic             out_mode;
  logic             out_err;
  logic             busy;

  modport slave (
    input  in_valid, in_mode, in_key, in_text,
    input  core_done, core_text_out,
    input  out_ready,
    output in_ready,
    output core_mode, core_ld, core_kld, core_key, core_text,
    output out_valid, out_text, out_mode, out_err, busy
  );

  modport master (
    output in_valid, in_mode, in_key, in_text,
    output core_done, core_text_out,
    output out_ready,
    input  in_ready,
    input  core_mode, core_ld, core_kld, core_key, core_text,
    input  out_valid, out_text, out_mode, out_err, busy
  );
endinterface

// File: rtl/aes_req_seq.sv
// Job sequencer and result buffer around aes_top: key-load/expansion for decrypt,
// single-pulse ld/kld, result hold with back-pressure and a RUN timeout watchdog.
module aes_req_seq #(
  parameter int unsigned KEXP_CYCLES = 12,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic         clk,
  input  logic         rst,
  aes_req_seq_if.slave bus
);
  localparam int unsigned BLK_W   = 128;
  localparam int unsigned CNT_MAX = (KEXP_CYCLES > TIMEOUT) ? KEXP_CYCLES : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, KLOAD, KWAIT, LOAD, RUN, HOLD} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             key_valid;
  logic [BLK_W-1:0] cached_key;

  logic accept;
  logic key_hit;
  logic kexp_last;
  logic run_done;
  logic run_timeout;

  // RUN entered with cnt=0 one cycle after ld, so the last allowed RUN cycle has cnt=TIMEOUT-2
  always_comb begin
    accept      = bus.in_valid && (state == IDLE);
    key_hit     = key_valid && (bus.in_key == cached_key);
    kexp_last   = (cnt == CNT_W'(KEXP_CYCLES - 1));
    run_done    = (state == RUN) && bus.core_done;
    run_timeout = (state == RUN) && !bus.core_done && (cnt == CNT_W'(TIMEOUT - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = (!bus.in_mode || key_hit) ? LOAD : KLOAD;
      KLOAD:   state_next = KWAIT;
      KWAIT:   if (kexp_last) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (run_done || run_timeout) state_next = HOLD;
      HOLD:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs are decoded from the next state so they line up with the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      key_valid     <= 1'b0;
      cached_key    <= '0;
      bus.in_ready  <= 1'b1;
      bus.busy      <= 1'b0;
      bus.core_ld   <= 1'b0;
      bus.core_kld  <= 1'b0;
      bus.core_mode <= 1'b0;
      bus.core_key  <= '0;
      bus.core_text <= '0;
      bus.out_valid <= 1'b0;
      bus.out_text  <= '0;
      bus.out_mode  <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      bus.in_ready  <= (state_next == IDLE);
      bus.busy      <= (state_next != IDLE);
      bus.core_ld   <= (state_next == LOAD);
      bus.core_kld  <= (state_next == KLOAD);
      bus.out_valid <= (state_next == HOLD);

      if (accept) begin
        bus.core_mode <= bus.in_mode;
        bus.core_key  <= bus.in_key;
        bus.core_text <= bus.in_text;
      end

      case (state)
        KLOAD: begin
          cached_key <= bus.core_key;
          key_valid  <= 1'b0;
          cnt        <= '0;
        end
        KWAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (kexp_last) key_valid <= 1'b1;
        end
        LOAD: cnt <= '0;
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (run_done) begin
            bus.out_text <= bus.core_text_out;
            bus.out_mode <= bus.core_mode;
            bus.out_err  <= 1'b0;
          end else if (run_timeout) begin
            // an aborted job leaves the core's key schedule in doubt
            bus.out_text <= '0;
            bus.out_mode <= bus.core_mode;
            bus.out_err  <= 1'b1;
            key_valid    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_req_seq.sv
// Self-checking bench for aes_req_seq: directed scenarios plus randomized jobs against a job-level model.
module tb_aes_req_seq;
  localparam int unsigned KEXP = 12;
  localparam int unsigned TMO  = 64;

  localparam logic [127:0] K_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  aes_req_seq_if bus ();

  aes_req_seq #(.KEXP_CYCLES(KEXP), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // job-level model: which key the core currently holds expanded
  bit           m_kv;
  logic [127:0] m_key;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // stand-in for aes_top: real vector for K_A, otherwise any deterministic function
  function automatic logic [127:0] core_resp(input logic mode, input logic [127:0] key,
                                             input logic [127:0] text);
    if (key == K_A && !mode && text == P_A) return C_A;
    if (key == K_A &&  mode && text == C_A) return P_A;
    return text ^ key ^ {128{mode}};
  endfunction

  task automatic check_reset_vals();
    check("rst_core_ld",   128'(bus.core_ld),   128'(0));
    check("rst_core_kld",  128'(bus.core_kld),  128'(0));
    check("rst_core_mode", 128'(bus.core_mode), 128'(0));
    check("rst_core_key",  bus.core_key,        128'(0));
    check("rst_core_text", bus.core_text,       128'(0));
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_out_text",  bus.out_text,        128'(0));
    check("rst_out_mode",  128'(bus.out_mode),  128'(0));
    check("rst_out_err",   128'(bus.out_err),   128'(0));
    check("rst_busy",      128'(bus.busy),      128'(0));
    check("rst_in_ready",  128'(bus.in_ready),  128'(1));
  endtask

  // One job from accept to output handshake; dly<=0 or >=TMO means core_done is withheld.
  task automatic run_job(input logic mode, input logic [127:0] key, input logic [127:0] text,
                         input int dly, input int hold, input bit spur);
    bit           exp_kld, to, got;
    int           acc, kld_n, ld_n, kld_c, ld_c, ov_c, both, bad, t, exp_ld, exp_ov;
    logic [127:0] exp_text, held;

    exp_kld  = mode && !(m_kv && key == m_key);
    to       = (dly <= 0) || (dly >= int'(TMO));
    exp_text = to ? 128'(0) : core_resp(mode, key, text);

    check("in_ready_idle", 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_key   = key;
    bus.in_text  = text;
    acc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_mode  = 1'($urandom_range(0, 1));
    bus.in_key   = rand128();
    bus.in_text  = rand128();

    kld_n = 0; ld_n = 0; kld_c = 0; ld_c = 0; ov_c = 0; both = 0; t = 0; got = 1'b0;
    while (!got && t < 200) begin
      if (bus.core_kld) begin kld_n++; kld_c = cyc; end
      if (bus.core_ld)  begin ld_n++;  ld_c  = cyc; end
      if (bus.core_kld && bus.core_ld) both++;
      if (bus.out_valid) begin
        got  = 1'b1;
        ov_c = cyc;
      end else begin
        bus.core_done     = 1'b0;
        bus.core_text_out = rand128();
        if (ld_n > 0 && !to && cyc == ld_c + dly) begin
          bus.core_done     = 1'b1;
          bus.core_text_out = exp_text;
        end else if (spur && ld_n == 0) begin
          bus.core_done = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        t++;
      end
    end
    bus.core_done = 1'b0;

    exp_ld = acc + (exp_kld ? 2 + int'(KEXP) : 1);
    exp_ov = exp_ld + (to ? int'(TMO) : dly + 1);
    check("result_seen", 128'(got), 128'(1));
    check("kld_count", 128'(kld_n), 128'(exp_kld));
    if (exp_kld) check("kld_lat", 128'(kld_c - acc), 128'(1));
    check("ld_count", 128'(ld_n), 128'(1));
    check("ld_lat", 128'(ld_c - acc), 128'(exp_ld - acc));
    check("kld_ld_overlap", 128'(both), 128'(0));
    check("ov_lat", 128'(ov_c - acc), 128'(exp_ov - acc));
    check("out_text", bus.out_text, exp_text);
    check("out_err", 128'(bus.out_err), 128'(to));
    if (!to) check("out_mode", 128'(bus.out_mode), 128'(mode));
    check("core_key", bus.core_key, key);
    check("core_text", bus.core_text, text);

    if (exp_kld) begin
      m_kv  = 1'b1;
      m_key = key;
    end
    if (to) m_kv = 1'b0;

    // back-pressure: a competing request and stray done pulses must not disturb the held result
    held         = bus.out_text;
    bad          = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      bus.core_done     = 1'($urandom_range(0, 1));
      bus.core_text_out = rand128();
      @(negedge clk);
      if (!bus.out_valid || bus.out_text !== held || bus.out_err !== to || bus.in_ready ||
          bus.core_ld || bus.core_kld || !bus.busy) bad++;
    end
    bus.core_done = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("hold_stable", 128'(bad), 128'(0));
    check("ov_drop", 128'(bus.out_valid), 128'(0));
    check("in_ready_ret", 128'(bus.in_ready), 128'(1));
    check("busy_ret", 128'(bus.busy), 128'(0));
  endtask

  // Start a job, then reset it n cycles after accept.
  task automatic reset_mid(input logic mode, input logic [127:0] key, input int n);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_key   = key;
    bus.in_text  = rand128();
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
    check("busy_pre_rst", 128'(bus.busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    m_kv = 1'b0;
    check_reset_vals();
    @(negedge clk);
    check("in_ready_post_rst", 128'(bus.in_ready), 128'(1));
  endtask

  task automatic idle_spurious(input int n);
    logic [127:0] held;
    int           bad;
    held = bus.out_text;
    bad  = 0;
    for (int i = 0; i < n; i++) begin
      bus.core_done     = 1'b1;
      bus.core_text_out = rand128();
      @(negedge clk);
      if (bus.out_valid || bus.busy || !bus.in_ready || bus.out_text !== held ||
          bus.core_ld || bus.core_kld) bad++;
    end
    bus.core_done = 1'b0;
    check("idle_spurious", 128'(bad), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k_b;
    logic [127:0] pool [3];

    rst               = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_mode       = 1'b0;
    bus.in_key        = '0;
    bus.in_text       = '0;
    bus.core_done     = 1'b0;
    bus.core_text_out = '0;
    bus.out_ready     = 1'b0;
    m_kv              = 1'b0;
    m_key             = '0;
    k_b               = rand128();

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals();

    reset_mid(1'b1, k_b, 6);                    // reset inside KWAIT
    run_job(1'b1, k_b, rand128(), 11, 0, 1'b0); // must re-issue kld
    run_job(1'b0, K_A, P_A, 11, 0, 1'b0);       // encrypt vector
    run_job(1'b1, K_A, C_A, 11, 0, 1'b1);       // new decrypt key, stray done in KWAIT
    run_job(1'b1, K_A, C_A, 11, 0, 1'b0);       // cached key
    run_job(1'b0, K_A, P_A, 11, 20, 1'b0);      // back-pressure
    idle_spurious(5);
    run_job(1'b1, K_A, C_A, 0, 0, 1'b0);        // timeout
    run_job(1'b1, K_A, C_A, 11, 0, 1'b0);       // re-kld after timeout
    run_job(1'b0, k_b, rand128(), 7, 0, 1'b0);  // interleaved encrypt
    run_job(1'b1, K_A, C_A, 5, 0, 1'b0);        // still cached
    run_job(1'b1, K_A, C_A, int'(TMO) - 1, 0, 1'b0); // done on the timeout cycle wins
    reset_mid(1'b1, K_A, 4);                    // reset inside RUN with a cached key
    run_job(1'b1, K_A, C_A, 3, 0, 1'b0);

    pool[0] = K_A;
    pool[1] = k_b;
    pool[2] = rand128();
    for (int j = 0; j < 40; j++) begin
      logic [127:0] key;
      int           d;
      key = pool[$urandom_range(0, 2)];
      d   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TMO - 1));
      run_job(1'($urandom_range(0, 1)), key, rand128(), d,
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
